// File: rtl/dispatch_credit_ctrl.sv
// Dispatch gate: grants the oldest in-order run of decoded slots that fits the
// ROB/RS/PRF/LSQ credit counters, and tracks those credits across release and flush.
module dispatch_credit_ctrl #(
    parameter int WIDTH     = 2,
    parameter int ROB_DEPTH = 32,
    parameter int RS_DEPTH  = 16,
    parameter int PRF_FREE  = 32,
    parameter int LSQ_DEPTH = 16,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int RW = $clog2(ROB_DEPTH + 1),
    localparam int SW = $clog2(RS_DEPTH + 1),
    localparam int PW = $clog2(PRF_FREE + 1),
    localparam int LW = $clog2(LSQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] slot_valid,
    input  logic [WIDTH-1:0] slot_is_mem,
    input  logic [WIDTH-1:0] slot_has_rd,
    input  logic [CW-1:0]    rob_retire_cnt,
    input  logic [CW-1:0]    rs_issue_cnt,
    input  logic [CW-1:0]    prf_free_cnt,
    input  logic [CW-1:0]    lsq_release_cnt,
    input  logic             flush,
    input  logic [PW-1:0]    flush_prf_free,
    output logic [WIDTH-1:0] dispatch_grant,
    output logic [CW-1:0]    dispatch_cnt,
    output logic             stall_frontend,
    output logic [RW-1:0]    rob_credit,
    output logic [SW-1:0]    rs_credit,
    output logic [PW-1:0]    prf_credit,
    output logic [LW-1:0]    lsq_credit,
    output logic             err_overflow
);

    // Wide enough that credit + release never wraps before the saturation compare.
    localparam int AW = $clog2(ROB_DEPTH + RS_DEPTH + PRF_FREE + LSQ_DEPTH + 4 * WIDTH + 1) + 1;

    logic [RW-1:0]    rob_credit_r;
    logic [SW-1:0]    rs_credit_r;
    logic [PW-1:0]    prf_credit_r;
    logic [LW-1:0]    lsq_credit_r;
    logic             err_overflow_r;

    logic [WIDTH-1:0] grant_s;
    logic             chain_s;
    logic             slot_ok_s;
    logic [AW-1:0]    rd_sum_s;
    logic [AW-1:0]    mem_sum_s;
    logic [AW-1:0]    disp_cnt_s;
    logic [AW-1:0]    rd_grant_s;
    logic [AW-1:0]    mem_grant_s;

    logic [AW-1:0]    rob_sum_s;
    logic [AW-1:0]    rs_sum_s;
    logic [AW-1:0]    prf_sum_s;
    logic [AW-1:0]    lsq_sum_s;
    logic             rob_ovf_s;
    logic             rs_ovf_s;
    logic             prf_ovf_s;
    logic             lsq_ovf_s;
    logic [RW-1:0]    rob_next_s;
    logic [SW-1:0]    rs_next_s;
    logic [PW-1:0]    prf_next_s;
    logic [LW-1:0]    lsq_next_s;

    // Prefix grant: each slot needs cumulative demand up to itself to fit the credits.
    always_comb begin
        grant_s     = {WIDTH{1'b0}};
        chain_s     = 1'b1;
        slot_ok_s   = 1'b0;
        rd_sum_s    = {AW{1'b0}};
        mem_sum_s   = {AW{1'b0}};
        disp_cnt_s  = {AW{1'b0}};
        rd_grant_s  = {AW{1'b0}};
        mem_grant_s = {AW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            rd_sum_s    = rd_sum_s + AW'(slot_has_rd[i]);
            mem_sum_s   = mem_sum_s + AW'(slot_is_mem[i]);
            slot_ok_s   = slot_valid[i] & chain_s & ~flush
                        & (AW'(i + 1) <= AW'(rob_credit_r))
                        & (AW'(i + 1) <= AW'(rs_credit_r))
                        & (rd_sum_s <= AW'(prf_credit_r))
                        & (mem_sum_s <= AW'(lsq_credit_r));
            grant_s[i]  = slot_ok_s;
            chain_s     = slot_ok_s;
            disp_cnt_s  = disp_cnt_s + AW'(slot_ok_s);
            rd_grant_s  = rd_grant_s + AW'(slot_ok_s & slot_has_rd[i]);
            mem_grant_s = mem_grant_s + AW'(slot_ok_s & slot_is_mem[i]);
        end
    end

    // Next credit values; anything above a structure's size saturates and flags overflow.
    always_comb begin
        rob_sum_s  = AW'(rob_credit_r) - disp_cnt_s + AW'(rob_retire_cnt);
        rs_sum_s   = AW'(rs_credit_r) - disp_cnt_s + AW'(rs_issue_cnt);
        prf_sum_s  = AW'(prf_credit_r) - rd_grant_s + AW'(prf_free_cnt);
        lsq_sum_s  = AW'(lsq_credit_r) - mem_grant_s + AW'(lsq_release_cnt);
        rob_ovf_s  = rob_sum_s > AW'(ROB_DEPTH);
        rs_ovf_s   = rs_sum_s > AW'(RS_DEPTH);
        prf_ovf_s  = prf_sum_s > AW'(PRF_FREE);
        lsq_ovf_s  = lsq_sum_s > AW'(LSQ_DEPTH);
        rob_next_s = rob_ovf_s ? RW'(ROB_DEPTH) : rob_sum_s[RW-1:0];
        rs_next_s  = rs_ovf_s  ? SW'(RS_DEPTH)  : rs_sum_s[SW-1:0];
        prf_next_s = prf_ovf_s ? PW'(PRF_FREE)  : prf_sum_s[PW-1:0];
        lsq_next_s = lsq_ovf_s ? LW'(LSQ_DEPTH) : lsq_sum_s[LW-1:0];
    end

    // Credit registers; a flush ignores all releases and restores the structure sizes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_credit_r   <= RW'(ROB_DEPTH);
            rs_credit_r    <= SW'(RS_DEPTH);
            prf_credit_r   <= PW'(PRF_FREE);
            lsq_credit_r   <= LW'(LSQ_DEPTH);
            err_overflow_r <= 1'b0;
        end else if (flush) begin
            rob_credit_r   <= RW'(ROB_DEPTH);
            rs_credit_r    <= SW'(RS_DEPTH);
            prf_credit_r   <= flush_prf_free;
            lsq_credit_r   <= LW'(LSQ_DEPTH);
            err_overflow_r <= err_overflow_r;
        end else begin
            rob_credit_r   <= rob_next_s;
            rs_credit_r    <= rs_next_s;
            prf_credit_r   <= prf_next_s;
            lsq_credit_r   <= lsq_next_s;
            err_overflow_r <= err_overflow_r | rob_ovf_s | rs_ovf_s | prf_ovf_s | lsq_ovf_s;
        end
    end

    // Grant is forced low during reset even though the credits already read full.
    assign dispatch_grant = grant_s & ~{WIDTH{rst}};
    assign dispatch_cnt   = rst ? {CW{1'b0}} : disp_cnt_s[CW-1:0];
    assign stall_frontend = |(slot_valid & ~dispatch_grant);
    assign rob_credit     = rob_credit_r;
    assign rs_credit      = rs_credit_r;
    assign prf_credit     = prf_credit_r;
    assign lsq_credit     = lsq_credit_r;
    assign err_overflow   = err_overflow_r;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Directed bench for dispatch_credit_ctrl with default parameters (2 slots,
// ROB 32, RS 16, PRF 32, LSQ 16); expected values are hand-computed.
module tb_dispatch_credit_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] slot_valid;
    logic [1:0] slot_is_mem;
    logic [1:0] slot_has_rd;
    logic [1:0] rob_retire_cnt;
    logic [1:0] rs_issue_cnt;
    logic [1:0] prf_free_cnt;
    logic [1:0] lsq_release_cnt;
    logic       flush;
    logic [5:0] flush_prf_free;
    logic [1:0] dispatch_grant;
    logic [1:0] dispatch_cnt;
    logic       stall_frontend;
    logic [5:0] rob_credit;
    logic [4:0] rs_credit;
    logic [5:0] prf_credit;
    logic [4:0] lsq_credit;
    logic       err_overflow;

    int checks;
    int errors;

    dispatch_credit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .slot_valid     (slot_valid),
        .slot_is_mem    (slot_is_mem),
        .slot_has_rd    (slot_has_rd),
        .rob_retire_cnt (rob_retire_cnt),
        .rs_issue_cnt   (rs_issue_cnt),
        .prf_free_cnt   (prf_free_cnt),
        .lsq_release_cnt(lsq_release_cnt),
        .flush          (flush),
        .flush_prf_free (flush_prf_free),
        .dispatch_grant (dispatch_grant),
        .dispatch_cnt   (dispatch_cnt),
        .stall_frontend (stall_frontend),
        .rob_credit     (rob_credit),
        .rs_credit      (rs_credit),
        .prf_credit     (prf_credit),
        .lsq_credit     (lsq_credit),
        .err_overflow   (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slot_valid      = 2'b00;
        slot_is_mem     = 2'b00;
        slot_has_rd     = 2'b00;
        rob_retire_cnt  = 2'd0;
        rs_issue_cnt    = 2'd0;
        prf_free_cnt    = 2'd0;
        lsq_release_cnt = 2'd0;
        flush           = 1'b0;
        flush_prf_free  = 6'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        slot_valid = 2'b11;
        #1;
        checks++;
        if (dispatch_grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b want 00", dispatch_grant);
        end
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow} !== {6'd32, 5'd16, 6'd32, 5'd16, 1'b0}) begin
            errors++;
            $display("FAIL reset_credits: got rob=%0d rs=%0d prf=%0d lsq=%0d err=%b want 32 16 32 16 0",
                     rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow);
        end
        step();
        step();
        rst = 1'b0;
        slot_valid = 2'b00;
    endtask

    task automatic test_basic_grant();
        slot_valid  = 2'b11;
        slot_has_rd = 2'b11;
        #1;
        checks++;
        if ({dispatch_grant, dispatch_cnt, stall_frontend} !== {2'b11, 2'd2, 1'b0}) begin
            errors++; $display("FAIL basic_grant: got grant=%b cnt=%0d stall=%b want 11 2 0",
                               dispatch_grant, dispatch_cnt, stall_frontend);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit} !== {6'd30, 5'd14, 6'd30, 5'd16}) begin
            errors++; $display("FAIL basic_credits: got %0d %0d %0d %0d want 30 14 30 16",
                               rob_credit, rs_credit, prf_credit, lsq_credit);
        end
    endtask

    task automatic test_lsq_limit();
        // Drain LSQ to 1 while retire/issue keep ROB and RS steady.
        slot_valid = 2'b11; slot_is_mem = 2'b11; rob_retire_cnt = 2'd2; rs_issue_cnt = 2'd2;
        for (int i = 0; i < 7; i++) step();
        slot_valid = 2'b01; rob_retire_cnt = 2'd0; rs_issue_cnt = 2'd0;
        step();
        checks++;
        if ({rob_credit, rs_credit, lsq_credit} !== {6'd29, 5'd13, 5'd1}) begin
            errors++; $display("FAIL lsq_setup: got rob=%0d rs=%0d lsq=%0d want 29 13 1",
                               rob_credit, rs_credit, lsq_credit);
        end
        slot_valid = 2'b11;
        #1;
        checks++;
        if ({dispatch_grant, dispatch_cnt, stall_frontend} !== {2'b01, 2'd1, 1'b1}) begin
            errors++; $display("FAIL lsq_grant: got grant=%b cnt=%0d stall=%b want 01 1 1",
                               dispatch_grant, dispatch_cnt, stall_frontend);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, lsq_credit} !== {6'd28, 5'd12, 5'd0}) begin
            errors++; $display("FAIL lsq_after: got rob=%0d rs=%0d lsq=%0d want 28 12 0",
                               rob_credit, rs_credit, lsq_credit);
        end
    endtask

    task automatic test_compaction();
        slot_valid = 2'b10;
        #1;
        checks++;
        if ({dispatch_grant, stall_frontend} !== {2'b00, 1'b1}) begin
            errors++; $display("FAIL compaction_grant: got grant=%b stall=%b want 00 1",
                               dispatch_grant, stall_frontend);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit} !== {6'd28, 5'd12, 6'd30, 5'd0}) begin
            errors++; $display("FAIL compaction_credits: got %0d %0d %0d %0d want 28 12 30 0",
                               rob_credit, rs_credit, prf_credit, lsq_credit);
        end
    endtask

    task automatic test_no_bypass();
        // Drain ROB from 28 to 0 with non-mem, no-rd slots; RS held by issue.
        slot_valid = 2'b11; rs_issue_cnt = 2'd2;
        for (int i = 0; i < 14; i++) step();
        rs_issue_cnt = 2'd0;
        checks++;
        if ({rob_credit, rs_credit} !== {6'd0, 5'd12}) begin
            errors++; $display("FAIL rob_drain: got rob=%0d rs=%0d want 0 12", rob_credit, rs_credit);
        end
        rob_retire_cnt = 2'd2;
        #1;
        checks++;
        if ({dispatch_grant, stall_frontend} !== {2'b00, 1'b1}) begin
            errors++; $display("FAIL no_bypass_grant: got grant=%b stall=%b want 00 1",
                               dispatch_grant, stall_frontend);
        end
        step();
        rob_retire_cnt = 2'd0;
        #1;
        checks++;
        if ({rob_credit, dispatch_grant} !== {6'd2, 2'b11}) begin
            errors++; $display("FAIL no_bypass_next: got rob=%0d grant=%b want 2 11", rob_credit, dispatch_grant);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit} !== {6'd0, 5'd10}) begin
            errors++; $display("FAIL no_bypass_after: got rob=%0d rs=%0d want 0 10", rob_credit, rs_credit);
        end
    endtask

    task automatic test_prf_limit();
        flush = 1'b1; flush_prf_free = 6'd1;
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit} !== {6'd32, 5'd16, 6'd1, 5'd16}) begin
            errors++; $display("FAIL prf_setup: got %0d %0d %0d %0d want 32 16 1 16",
                               rob_credit, rs_credit, prf_credit, lsq_credit);
        end
        slot_valid = 2'b11; slot_has_rd = 2'b11;
        #1;
        checks++;
        if (dispatch_grant !== 2'b01) begin
            errors++; $display("FAIL prf_both_rd: got grant=%b want 01", dispatch_grant);
        end
        slot_has_rd = 2'b10;
        #1;
        checks++;
        if ({dispatch_grant, dispatch_cnt} !== {2'b11, 2'd2}) begin
            errors++; $display("FAIL prf_one_rd: got grant=%b cnt=%0d want 11 2", dispatch_grant, dispatch_cnt);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit} !== {6'd30, 5'd14, 6'd0}) begin
            errors++; $display("FAIL prf_after: got rob=%0d rs=%0d prf=%0d want 30 14 0",
                               rob_credit, rs_credit, prf_credit);
        end
    endtask

    task automatic test_flush();
        slot_valid = 2'b11; flush = 1'b1; flush_prf_free = 6'd20;
        rs_issue_cnt = 2'd2; rob_retire_cnt = 2'd1; lsq_release_cnt = 2'd1; prf_free_cnt = 2'd2;
        #1;
        checks++;
        if ({dispatch_grant, dispatch_cnt, stall_frontend} !== {2'b00, 2'd0, 1'b1}) begin
            errors++; $display("FAIL flush_grant: got grant=%b cnt=%0d stall=%b want 00 0 1",
                               dispatch_grant, dispatch_cnt, stall_frontend);
        end
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow} !== {6'd32, 5'd16, 6'd20, 5'd16, 1'b0}) begin
            errors++; $display("FAIL flush_credits: got %0d %0d %0d %0d err=%b want 32 16 20 16 0",
                               rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow);
        end
    endtask

    task automatic test_overflow();
        rob_retire_cnt = 2'd1;
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, err_overflow} !== {6'd32, 1'b1}) begin
            errors++; $display("FAIL overflow_set: got rob=%0d err=%b want 32 1", rob_credit, err_overflow);
        end
        step();
        step();
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got err=%b want 1", err_overflow);
        end
    endtask

    task automatic test_async_reset();
        slot_valid = 2'b11; slot_has_rd = 2'b11;
        step();
        step();
        checks++;
        if ({rob_credit, prf_credit} !== {6'd28, 6'd16}) begin
            errors++; $display("FAIL async_setup: got rob=%0d prf=%0d want 28 16", rob_credit, prf_credit);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dispatch_grant, rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow}
            !== {2'b00, 6'd32, 5'd16, 6'd32, 5'd16, 1'b0}) begin
            errors++; $display("FAIL async_reset: got grant=%b %0d %0d %0d %0d err=%b want 00 32 16 32 16 0",
                               dispatch_grant, rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow);
        end
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back_release();
        slot_valid = 2'b11; slot_is_mem = 2'b01; slot_has_rd = 2'b10;
        rob_retire_cnt = 2'd1; rs_issue_cnt = 2'd2; prf_free_cnt = 2'd1; lsq_release_cnt = 2'd1;
        #1;
        checks++;
        if (dispatch_grant !== 2'b11) begin
            errors++; $display("FAIL mixed_grant: got grant=%b want 11", dispatch_grant);
        end
        step();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow} !== {6'd31, 5'd16, 6'd32, 5'd16, 1'b0}) begin
            errors++; $display("FAIL mixed_credits1: got %0d %0d %0d %0d err=%b want 31 16 32 16 0",
                               rob_credit, rs_credit, prf_credit, lsq_credit, err_overflow);
        end
        rob_retire_cnt = 2'd0; rs_issue_cnt = 2'd0; prf_free_cnt = 2'd0; lsq_release_cnt = 2'd0;
        step();
        idle_inputs();
        checks++;
        if ({rob_credit, rs_credit, prf_credit, lsq_credit} !== {6'd29, 5'd14, 6'd31, 5'd15}) begin
            errors++; $display("FAIL mixed_credits2: got %0d %0d %0d %0d want 29 14 31 15",
                               rob_credit, rs_credit, prf_credit, lsq_credit);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_grant();
        test_lsq_limit();
        test_compaction();
        test_no_bypass();
        test_prf_limit();
        test_flush();
        test_overflow();
        test_async_reset();
        test_back_to_back_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
